// File: rtl/conv_layer_param.sv
// conv_layer_param: streaming 2D valid convolution (stride 1, no padding).
// A raster pixel stream fills K-1 line buffers and a KxK window register;
// OUT_CH channels then multiply, add and saturate in parallel through a
// three-stage pipeline (products, adder tree + bias, shift/saturate).
// Weights and biases are written at runtime while the layer is idle.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   valid_in, sof    pixel qualifier, start-of-frame (pixel (0,0))
//   data_in          signed pixel in raster order
//   wt_we/addr/data  weight/bias write port: addr 0..OUT_CH*K*K-1 are weights
//                    (ch*K*K + r*K + c), the next OUT_CH addresses are biases
//   conv_out         packed channel results, channel 0 in the LSBs
//   valid_out        conv_out valid (3 cycles after the completing pixel)
//   frame_done       pulse with the last result of a frame
//   busy             frame in progress; weight writes are rejected
//   wt_err           pulse the cycle after a rejected write
//
// Build option: define CONV_LAYER_RELU_EN to clamp negative results to 0.
module conv_layer_param #(
    parameter int WIDTH     = 28,
    parameter int HEIGHT    = 28,
    parameter int K         = 5,
    parameter int OUT_CH    = 3,
    parameter int DATA_BITS = 8,
    parameter int W_BITS    = 8,
    parameter int OUT_BITS  = 12,
    parameter int SHIFT     = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   valid_in,
    input  logic                                   sof,
    input  logic signed [DATA_BITS-1:0]            data_in,
    input  logic                                   wt_we,
    input  logic [$clog2(OUT_CH*K*K+OUT_CH)-1:0]   wt_addr,
    input  logic signed [W_BITS-1:0]               wt_data,
    output logic [OUT_CH*OUT_BITS-1:0]             conv_out,
    output logic                                   valid_out,
    output logic                                   frame_done,
    output logic                                   busy,
    output logic                                   wt_err
);
    localparam int KK    = K * K;
    localparam int NW    = OUT_CH * KK;
    localparam int NA    = NW + OUT_CH;
    localparam int PW    = DATA_BITS + W_BITS;
    localparam int ACC_W = PW + $clog2(KK) + 1;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [OUT_BITS-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0]    s;
        logic signed [OUT_BITS-1:0] r;
        s = v >>> SHIFT;
        if (s > SAT_MAX)      r = SAT_MAX[OUT_BITS-1:0];
        else if (s < SAT_MIN) r = SAT_MIN[OUT_BITS-1:0];
        else                  r = s[OUT_BITS-1:0];
`ifdef CONV_LAYER_RELU_EN
        if (r[OUT_BITS-1]) r = '0;
`endif
        return r;
    endfunction

    logic [CW-1:0] col, pos_col;
    logic [RW-1:0] row, pos_row;
    logic          win_done, frame_last, addr_ok;

    logic signed [W_BITS-1:0]    wt   [NW];
    logic signed [W_BITS-1:0]    bias [OUT_CH];
    logic signed [DATA_BITS-1:0] lb      [K-1][WIDTH];
    logic signed [DATA_BITS-1:0] win_reg [K][K-1];
    logic signed [DATA_BITS-1:0] cur_col [K];
    logic signed [DATA_BITS-1:0] win_c   [KK];

    logic signed [PW-1:0]    prod_p0 [OUT_CH][KK];
    logic                    vld_p0, last_p0;
    logic signed [ACC_W-1:0] sum_c   [OUT_CH];
    logic signed [ACC_W-1:0] sum_p1  [OUT_CH];
    logic                    vld_p1, last_p1;

    // sof forces the current pixel to (0,0) regardless of the counters
    always_comb begin
        pos_col    = sof ? '0 : col;
        pos_row    = sof ? '0 : row;
        win_done   = valid_in && (pos_col >= COL_MIN) && (pos_row >= ROW_MIN);
        frame_last = win_done && (pos_col == COL_LAST) && (pos_row == ROW_LAST);
        addr_ok    = 32'(wt_addr) < 32'(NA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end
    end

    // Counters back at (0,0) means no later frame has started, so the
    // frame_done just presented really ends the activity.
    always_ff @(posedge clk) begin
        if (rst)                                       busy <= 1'b0;
        else if (valid_in)                             busy <= 1'b1;
        else if (frame_done && col == '0 && row == '0) busy <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++)     wt[i]   <= '0;
            for (int i = 0; i < OUT_CH; i++) bias[i] <= '0;
            wt_err <= 1'b0;
        end else begin
            wt_err <= wt_we && (busy || !addr_ok);
            if (wt_we && !busy && addr_ok) begin
                for (int i = 0; i < NW; i++)
                    if (32'(wt_addr) == 32'(i)) wt[i] <= wt_data;
                for (int i = 0; i < OUT_CH; i++)
                    if (32'(wt_addr) == 32'(NW + i)) bias[i] <= wt_data;
            end
        end
    end

    // Window column: row K-1 is the live pixel, row K-2-j comes from line buffer j
    always_comb begin
        for (int r = 0; r < K; r++) cur_col[r] = '0;
        cur_col[K-1] = data_in;
        for (int j = 0; j < K - 1; j++) cur_col[K-2-j] = lb[j][WIDTH-1];
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win_c[r*K+c] = win_reg[r][c];
            win_c[r*K+K-1] = cur_col[r];
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int j = 0; j < K - 1; j++) begin
                lb[j][0] <= cur_col[K-1-j];
                for (int i = 1; i < WIDTH; i++) lb[j][i] <= lb[j][i-1];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 2; c++) win_reg[r][c] <= win_reg[r][c+1];
                win_reg[r][K-2] <= cur_col[r];
            end
        end
    end

    // ---- stage 1: products ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= win_done;
            last_p0 <= frame_last;
        end
    end

    always_ff @(posedge clk) begin
        if (win_done)
            for (int ch = 0; ch < OUT_CH; ch++)
                for (int i = 0; i < KK; i++)
                    prod_p0[ch][i] <= PW'(win_c[i]) * PW'(wt[ch*KK+i]);
    end

    // ---- stage 2: adder tree plus pre-scaled bias ----
    always_comb begin
        for (int ch = 0; ch < OUT_CH; ch++) begin
            sum_c[ch] = ACC_W'(bias[ch]) <<< SHIFT;
            for (int i = 0; i < KK; i++) sum_c[ch] = sum_c[ch] + ACC_W'(prod_p0[ch][i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0)
            for (int ch = 0; ch < OUT_CH; ch++) sum_p1[ch] <= sum_c[ch];
    end

    // ---- stage 3: shift, saturate, output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= vld_p1;
            frame_done <= last_p1;
            if (vld_p1)
                for (int ch = 0; ch < OUT_CH; ch++)
                    conv_out[ch*OUT_BITS +: OUT_BITS] <= sat_out(sum_p1[ch]);
        end
    end

endmodule

// File: tb/tb_conv_layer_param.sv
// Scoreboard bench for conv_layer_param on a 6x6 frame, 3x3 kernel, 3 channels.
module tb_conv_layer_param;
    logic              clk = 1'b0;
    logic              rst, valid_in, sof, wt_we;
    logic signed [7:0] data_in, wt_data;
    logic [4:0]        wt_addr;
    logic [35:0]       conv_out;
    logic              valid_out, frame_done, busy, wt_err;

    always #5 clk = ~clk;

    conv_layer_param #(
        .WIDTH(6), .HEIGHT(6), .K(3), .OUT_CH(3),
        .DATA_BITS(8), .W_BITS(8), .OUT_BITS(12), .SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .sof(sof), .data_in(data_in),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .conv_out(conv_out), .valid_out(valid_out), .frame_done(frame_done),
        .busy(busy), .wt_err(wt_err)
    );

    typedef struct {
        logic signed [11:0] c0, c1, c2;
        logic               fd;
        int                 cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   out_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic signed [11:0] rl(input int v);
`ifdef CONV_LAYER_RELU_EN
        if (v < 0) return 12'sd0;
`endif
        return 12'(v);
    endfunction

    task automatic monitor_loop();
        exp_t e;
        logic signed [11:0] g0, g1, g2;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_cnt = 0;
            end else if (valid_out) begin
                g0 = conv_out[11:0];
                g1 = conv_out[23:12];
                g2 = conv_out[35:24];
                if (q.size() == 0) begin
                    chk("unexpected_valid_out", valid_out, 0);
                end else begin
                    e = q.pop_front();
                    chk("ch0", g0, e.c0);
                    chk("ch1", g1, e.c1);
                    chk("ch2", g2, e.c2);
                    chk("frame_done_flag", frame_done, e.fd);
                    chk("latency_cycle", cyc, e.cyc);
                end
                out_cnt++;
                if (frame_done) begin
                    chk("outputs_per_frame", out_cnt, 16);
                    out_cnt = 0;
                end
            end else if (frame_done) begin
                chk("frame_done_without_valid", frame_done, 0);
            end
        end
    endtask

    task automatic load(input int w0, input int w1, input int w2,
                        input int b0, input int b1, input int b2);
        int v;
        for (int a = 0; a < 30; a++) begin
            @(negedge clk);
            v = (a < 9) ? w0 : (a < 18) ? w1 : (a < 27) ? w2 :
                (a == 27) ? b0 : (a == 28) ? b1 : b2;
            wt_we   = 1'b1;
            wt_addr = 5'(a);
            wt_data = 8'(v);
        end
        @(negedge clk);
        wt_we = 1'b0;
        chk("wt_err_on_idle_load", wt_err, 0);
    endtask

    task automatic send_partial(input int n, input int pix, input logic use_sof);
        for (int idx = 0; idx < n; idx++) begin
            @(negedge clk);
            valid_in = 1'b1;
            data_in  = 8'(pix);
            sof      = (idx == 0) && use_sof;
        end
    endtask

    task automatic send_frame(input int pix, input logic gap, input int e0, input int e1,
                              input int e2, input int wr_idx, input int wr_addr,
                              input int wr_data, input logic err_exp, input logic use_sof);
        exp_t e;
        for (int idx = 0; idx < 36; idx++) begin
            @(negedge clk);
            if (idx == 1) chk("busy_after_first_pixel", busy, 1);
            if (wr_idx >= 0 && idx == wr_idx + 1) chk("wt_err_pulse", wt_err, err_exp);
            if (wr_idx >= 0 && idx == wr_idx + 2) chk("wt_err_single_cycle", wt_err, 0);
            valid_in = 1'b1;
            data_in  = 8'(pix);
            sof      = (idx == 0) && use_sof;
            wt_we    = (idx == wr_idx);
            wt_addr  = 5'(wr_addr);
            wt_data  = 8'(wr_data);
            if ((idx / 6) >= 2 && (idx % 6) >= 2) begin
                e.c0  = rl(e0);
                e.c1  = rl(e1);
                e.c2  = rl(e2);
                e.fd  = (idx == 35);
                e.cyc = cyc + 3;
                q.push_back(e);
            end
            if (gap) begin
                @(negedge clk);
                valid_in = 1'b0;
                sof      = 1'b0;
                wt_we    = 1'b0;
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        sof      = 1'b0;
        wt_we    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending_results", q.size(), 0);
        @(negedge clk);
        chk("busy_low_after_frame", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid_out"}, valid_out, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wt_err"}, wt_err, 0);
        chk({tag, "_conv_out"}, conv_out, 0);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; sof = 1'b0; data_in = '0;
        wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        fork
            monitor_loop();
        join_none
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // basic frame, then the same data with a gap every other cycle
        load(1, -1, 2, 0, 0, 5);
        send_frame(2, 1'b0, 18, -18, 41, -1, 0, 0, 1'b0, 1'b0);
        drain();
        send_frame(2, 1'b1, 18, -18, 41, -1, 0, 0, 1'b0, 1'b1);
        drain();

        // saturation at both rails, then a mixed-sign frame
        load(127, 127, 127, 0, 0, 0);
        send_frame(127, 1'b0, 2047, 2047, 2047, -1, 0, 0, 1'b0, 1'b1);
        drain();
        load(-128, -128, -128, 0, 0, 0);
        send_frame(127, 1'b0, -2048, -2048, -2048, -1, 0, 0, 1'b0, 1'b1);
        drain();
        load(127, -128, 1, 0, 0, -7);
        send_frame(-3, 1'b0, -2048, 2047, -34, -1, 0, 0, 1'b0, 1'b1);
        drain();

        // out-of-range address while idle
        @(negedge clk);
        wt_we = 1'b1; wt_addr = 5'd30; wt_data = 8'sd9;
        @(negedge clk);
        wt_we = 1'b0;
        chk("wt_err_out_of_range", wt_err, 1);
        @(negedge clk);
        chk("wt_err_out_of_range_clear", wt_err, 0);

        // partial frame abandoned by sof, then a full frame
        load(1, -1, 2, 0, 0, 5);
        send_partial(10, 7, 1'b0);
        send_frame(2, 1'b0, 18, -18, 41, -1, 0, 0, 1'b0, 1'b1);
        drain();

        // write while busy is rejected and leaves the frame unchanged
        send_frame(2, 1'b0, 18, -18, 41, 8, 0, 5, 1'b1, 1'b1);
        drain();
        // same write while idle is accepted
        @(negedge clk);
        wt_we = 1'b1; wt_addr = 5'd0; wt_data = 8'sd5;
        @(negedge clk);
        wt_we = 1'b0;
        chk("wt_err_idle_write", wt_err, 0);
        // bias write on the first pixel of a frame applies to that frame
        send_frame(2, 1'b0, 29, -18, 41, 0, 27, 3, 1'b0, 1'b1);
        drain();

        // reset mid-frame with a result in flight
        send_partial(15, 2, 1'b1);
        @(negedge clk);
        valid_in = 1'b0; sof = 1'b0; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_stale_valid_out", valid_out, 0);
        send_frame(2, 1'b0, 0, 0, 0, -1, 0, 0, 1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_layer_param.md
Name: conv_layer_param

Overview:
Parametrised streaming 2D convolution layer for the CNN datapath. It is the successor to the fixed 28x28 / 5x5 / 3-channel conv stage.
- Internal line buffers build a KxK window from a raster pixel stream.
- OUT_CH channels compute in parallel, each with its own weights and bias.
- Weights and biases load at runtime through a write port instead of being hard-coded.
- Sits between the input image stream (or a previous pool layer) and the next pool/ReLU stage.

Parameters:
WIDTH, 28, input frame width in pixels
HEIGHT, 28, input frame height in pixels
K, 5, kernel size (KxK, valid convolution, stride 1, no padding)
OUT_CH, 3, number of output channels
DATA_BITS, 8, signed input pixel width
W_BITS, 8, signed weight/bias width
OUT_BITS, 12, signed output width per channel
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_in  in  1  qualifies data_in
sof  in  1  start-of-frame; sampled only with valid_in; marks pixel (0,0)
data_in  in  DATA_BITS  signed pixel, raster order
wt_we  in  1  weight/bias write strobe
wt_addr  in  clog2(OUT_CH*K*K+OUT_CH)  0..OUT_CH*K*K-1 = weights (ch*K*K+r*K+c); then OUT_CH biases
wt_data  in  W_BITS  signed weight/bias value
conv_out  out  OUT_CH*OUT_BITS  packed results, channel 0 in LSBs
valid_out  out  1  conv_out valid
frame_done  out  1  one-cycle pulse coincident with the last valid_out of a frame
busy  out  1  high from the first accepted pixel of a frame until its frame_done
wt_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous and active-high.
- Reset values:
  - conv_out, valid_out, frame_done, busy, wt_err = 0.
  - Column/row counters = 0; pipeline valids cleared.
  - All weights and biases = 0.
- Position tracking: column counter counts 0..WIDTH-1 and row counter 0..HEIGHT-1, advancing only on valid_in. After pixel (HEIGHT-1, WIDTH-1) both wrap to 0; the next pixel begins a new frame.
- sof with valid_in: the current pixel is taken as (0,0). The counters and the window-valid state restart. A partial frame produces no further outputs and no frame_done. busy stays high.
- Window:
  - K-1 line buffers of WIDTH entries plus a KxK shift register.
  - A window is complete on the pixel with col>=K-1 and row>=K-1.
  - Output frame is (WIDTH-K+1) x (HEIGHT-K+1), raster order.
- Pipeline, fixed latency 3 clk from the completing valid_in beat to valid_out:
  - S1: registered products.
  - S2: adder tree plus bias.
  - S3: shift, saturate, output register.
- Gaps in valid_in stall nothing inside the pipeline: in-flight results still emerge. A gap only delays later windows.
- Arithmetic:
  - Products are DATA_BITS+W_BITS signed.
  - Accumulator is DATA_BITS+W_BITS+clog2(K*K)+1 bits; it cannot overflow.
  - Bias is sign-extended and left-shifted by SHIFT before the add.
  - Result = sum >>> SHIFT, then saturated to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
- Weight writes:
  - Accepted only when busy=0; the value is visible for the next frame.
  - wt_we with busy=1, or with an out-of-range wt_addr, is ignored and wt_err pulses the following cycle.
  - A write accepted on the same cycle as the first pixel of a frame: busy is still 0, so the write takes effect, and that frame uses the new value.
- busy:
  - Rises on the cycle after the first valid_in of a frame.
  - Falls on the cycle after frame_done.
  - A new frame's first pixel on the same cycle as frame_done keeps busy high.
- Reset mid-frame: everything returns to reset values, weights included. No stale valid_out after rst is deasserted.
- No backpressure: the downstream stage must accept one result per cycle.

Optional Feature:
- Macro CONV_LAYER_RELU_EN.
- Defined: after saturation, negative channel results are forced to 0. This adds no latency.
- Undefined: signed saturated results pass unchanged.

Test Plan:
- Reset: assert rst 2 cycles mid-stream -> all outputs 0; no valid_out until a fresh window completes; loaded weights read back as 0 effect (all-zero outputs).
- Basic (WIDTH=HEIGHT=6, K=3, OUT_CH=3): weights ch0=1, ch1=-1, ch2=2, biases 0/0/5, all pixels 2. Expected: exactly 16 valid_out, each {ch0=18, ch1=-18, ch2=41}, the first 3 cycles after pixel (2,2), frame_done with the 16th.
- Saturation (OUT_BITS=12): all weights 127, all pixels 127 -> 2047; weights -128, pixels 127 -> -2048; with CONV_LAYER_RELU_EN the negative case gives 0.
- Gappy input: valid_in high every other cycle with the basic-case data -> identical 16 results in order, no duplicates, latency 3 from each completing beat.
- sof restart: after 10 pixels, assert sof with a new pixel -> no outputs from the partial frame; a full frame then yields exactly 16 outputs and one frame_done.
- Write during busy: wt_we mid-frame -> wt_err pulses once, that frame's outputs unchanged. The same write after frame_done is accepted and changes the next frame's results.
